// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: widths, op codes, FSM states.
package lsu_pkg;

    localparam int DATA_W  = 16;
    localparam int CADDR_W = 10;
    localparam int RADDR_W = 5;
    localparam int CNT_W   = 3;

    typedef enum logic [1:0] {
        OP_LW  = 2'b00,
        OP_SW  = 2'b01,
        OP_LWM = 2'b10,
        OP_SWM = 2'b11
    } lsu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        STORE = 2'b10
    } lsu_state_e;

    // Loads have a zero in bit 0 of the op code.
    function automatic logic op_is_load(input logic [1:0] op);
        return ~op[0];
    endfunction

    // Beats minus one: single-word ops ignore the count field.
    function automatic logic [CNT_W-1:0] beats_minus_one(input logic [1:0] op,
                                                         input logic [CNT_W-1:0] cnt);
        return op[1] ? cnt : '0;
    endfunction

endpackage

// File: rtl/lsu_beat_ctr.sv
// Walks the cache address, register index and remaining-beat count of a burst.
module lsu_beat_ctr
    import lsu_pkg::*;
(
    input  logic               clk,
    input  logic               Reset,
    input  logic               load,
    input  logic               advance,
    input  logic [CADDR_W-1:0] load_addr,
    input  logic [RADDR_W-1:0] load_reg,
    input  logic [CNT_W-1:0]   load_rem,
    output logic [CADDR_W-1:0] cur_addr,
    output logic [RADDR_W-1:0] cur_reg,
    output logic               last_beat
);

    logic [CNT_W-1:0] remaining;

    // Load a new burst on accept, otherwise step both pointers once per beat (wrapping naturally).
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            cur_addr  <= '0;
            cur_reg   <= '0;
            remaining <= '0;
        end else if (load) begin
            cur_addr  <= load_addr;
            cur_reg   <= load_reg;
            remaining <= load_rem;
        end else if (advance) begin
            cur_addr  <= cur_addr + CADDR_W'(1);
            cur_reg   <= cur_reg + RADDR_W'(1);
            remaining <= remaining - CNT_W'(1);
        end
    end

    assign last_beat = (remaining == '0);

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one request at a time, one word per cycle between cache and register file.
module lsu_ctrl
    import lsu_pkg::*;
(
    input  logic               clk,
    input  logic               Reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [CADDR_W-1:0] req_addr,
    input  logic [RADDR_W-1:0] req_reg,
    input  logic [CNT_W-1:0]   req_cnt,
    input  logic [DATA_W-1:0]  req_sdata,
    output logic               c_write,
    output logic [CADDR_W-1:0] c_waddr,
    output logic [DATA_W-1:0]  c_wdata,
    output logic [CADDR_W-1:0] c_raddr,
    input  logic [DATA_W-1:0]  c_rdata,
    output logic               rf_write,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic [RADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0]  rf_rdata,
    output logic               done
);

    lsu_state_e         state;
    logic               accept;
    logic               beat_active;
    logic               last_beat;
    logic               store_from_rf;
    logic [DATA_W-1:0]  sdata_q;
    logic [CADDR_W-1:0] cur_addr;
    logic [RADDR_W-1:0] cur_reg;
    logic [RADDR_W-1:0] next_reg;

    assign accept      = req_valid && req_ready && (state == IDLE);
    assign beat_active = (state == LOAD) || (state == STORE);
    assign next_reg    = cur_reg + RADDR_W'(1);

    lsu_beat_ctr u_beat_ctr (
        .clk       (clk),
        .Reset     (Reset),
        .load      (accept),
        .advance   (beat_active),
        .load_addr (req_addr),
        .load_reg  (req_reg),
        .load_rem  (beats_minus_one(req_op, req_cnt)),
        .cur_addr  (cur_addr),
        .cur_reg   (cur_reg),
        .last_beat (last_beat)
    );

    // Sequencer FSM with registered handshake, enables and done pulse; r0 is never written.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state         <= IDLE;
            req_ready     <= 1'b0;
            done          <= 1'b0;
            c_write       <= 1'b0;
            rf_write      <= 1'b0;
            store_from_rf <= 1'b0;
            sdata_q       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state         <= op_is_load(req_op) ? LOAD : STORE;
                        req_ready     <= 1'b0;
                        c_write       <= ~op_is_load(req_op);
                        rf_write      <= op_is_load(req_op) && (req_reg != '0);
                        store_from_rf <= (req_op == OP_SWM);
                        sdata_q       <= req_sdata;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (last_beat) begin
                        state     <= IDLE;
                        rf_write  <= 1'b0;
                        done      <= 1'b1;
                        req_ready <= 1'b1;
                    end else begin
                        rf_write <= (next_reg != '0);
                    end
                end
                STORE: begin
                    if (last_beat) begin
                        state     <= IDLE;
                        c_write   <= 1'b0;
                        done      <= 1'b1;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    c_write   <= 1'b0;
                    rf_write  <= 1'b0;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

    assign c_raddr  = cur_addr;
    assign c_waddr  = cur_addr;
    assign rf_waddr = cur_reg;
    assign rf_raddr = cur_reg;
    assign rf_wdata = c_rdata;
    assign c_wdata  = store_from_rf ? rf_rdata : sdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl with bench-owned cache/register-file memories and a word-level model.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic               clk;
    logic               Reset;
    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_op;
    logic [CADDR_W-1:0] req_addr;
    logic [RADDR_W-1:0] req_reg;
    logic [CNT_W-1:0]   req_cnt;
    logic [DATA_W-1:0]  req_sdata;
    logic               c_write;
    logic [CADDR_W-1:0] c_waddr;
    logic [DATA_W-1:0]  c_wdata;
    logic [CADDR_W-1:0] c_raddr;
    logic [DATA_W-1:0]  c_rdata;
    logic               rf_write;
    logic [RADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]  rf_wdata;
    logic [RADDR_W-1:0] rf_raddr;
    logic [DATA_W-1:0]  rf_rdata;
    logic               done;

    logic [DATA_W-1:0] cacheMem [0:1023];
    logic [DATA_W-1:0] rfMem    [0:31];
    logic [DATA_W-1:0] expCache [0:1023];
    logic [DATA_W-1:0] expRf    [0:31];
    logic              doPreload;

    int testsRun;
    int testsFailed;
    int waited;

    lsu_ctrl dut (
        .clk       (clk),
        .Reset     (Reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_reg   (req_reg),
        .req_cnt   (req_cnt),
        .req_sdata (req_sdata),
        .c_write   (c_write),
        .c_waddr   (c_waddr),
        .c_wdata   (c_wdata),
        .c_raddr   (c_raddr),
        .c_rdata   (c_rdata),
        .rf_write  (rf_write),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .done      (done)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cache and register file: combinational reads, writes captured at the end of the cycle.
    always @(posedge clk) begin
        if (doPreload) begin
            for (int i = 0; i < 1024; i++) cacheMem[i] <= expCache[i];
            for (int i = 0; i < 32; i++) rfMem[i] <= expRf[i];
        end else begin
            if (c_write) cacheMem[c_waddr] <= c_wdata;
            if (rf_write) rfMem[rf_waddr] <= rf_wdata;
        end
    end

    assign c_rdata  = cacheMem[c_raddr];
    assign rf_rdata = rfMem[rf_raddr];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkMemories(input string tag);
        int badCache;
        int badRf;
        badCache = 0;
        badRf = 0;
        for (int i = 0; i < 1024; i++) if (cacheMem[i] !== expCache[i]) badCache++;
        for (int i = 0; i < 32; i++) if (rfMem[i] !== expRf[i]) badRf++;
        checkOutput({tag, "_cacheBadWords"}, badCache, 0);
        checkOutput({tag, "_rfBadWords"}, badRf, 0);
    endtask

    // Issue one request, check every beat against the model, then the done cycle and memories.
    task automatic applyStimulus(input logic [1:0] op, input logic [CADDR_W-1:0] addr,
                                 input logic [RADDR_W-1:0] rg, input logic [CNT_W-1:0] cnt,
                                 input logic [DATA_W-1:0] sdata, input bit hold, output int waitCycles);
        int n;
        bit isLoad;
        logic [CADDR_W-1:0] ea [8];
        logic [RADDR_W-1:0] er [8];
        logic [DATA_W-1:0]  ed [8];

        isLoad = (op == OP_LW) || (op == OP_LWM);
        n = (op == OP_LWM || op == OP_SWM) ? int'(cnt) + 1 : 1;
        for (int i = 0; i < n; i++) begin
            ea[i] = addr + CADDR_W'(i);
            er[i] = rg + RADDR_W'(i);
            if (isLoad) ed[i] = expCache[ea[i]];
            else if (op == OP_SW) ed[i] = sdata;
            else ed[i] = expRf[er[i]];
        end
        for (int i = 0; i < n; i++) begin
            if (isLoad) begin
                if (er[i] != 0) expRf[er[i]] = ed[i];
            end else begin
                expCache[ea[i]] = ed[i];
            end
        end

        waitCycles = 0;
        while (!req_ready && waitCycles < 10) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("readyBeforeReq", req_ready, 1);

        req_op    = op;
        req_addr  = addr;
        req_reg   = rg;
        req_cnt   = cnt;
        req_sdata = sdata;
        req_valid = 1'b1;
        @(posedge clk);

        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) req_valid = 1'b0;
            checkOutput("beatDoneLow", done, 0);
            checkOutput("beatReadyLow", req_ready, 0);
            if (isLoad) begin
                checkOutput("ldCWrite", c_write, 0);
                checkOutput("ldRfWrite", rf_write, (er[k-1] != 0));
                checkOutput("ldCRaddr", c_raddr, ea[k-1]);
                if (er[k-1] != 0) begin
                    checkOutput("ldRfWaddr", rf_waddr, er[k-1]);
                    checkOutput("ldRfWdata", rf_wdata, ed[k-1]);
                end
            end else begin
                checkOutput("stRfWrite", rf_write, 0);
                checkOutput("stCWrite", c_write, 1);
                checkOutput("stCWaddr", c_waddr, ea[k-1]);
                checkOutput("stCWdata", c_wdata, ed[k-1]);
            end
        end

        @(negedge clk);
        if (n == 0) req_valid = 1'b0;
        checkOutput("doneHigh", done, 1);
        checkOutput("readyAtDone", req_ready, 1);
        checkOutput("cWriteAtDone", c_write, 0);
        checkOutput("rfWriteAtDone", rf_write, 0);
        checkMemories("afterReq");
    endtask

    // Directed scenarios followed by randomized requests.
    initial begin
        testsRun = 0;
        testsFailed = 0;
        doPreload = 1'b0;
        Reset = 1'b0;
        req_valid = 1'b1;
        req_op = OP_LW;
        req_addr = '0;
        req_reg = '0;
        req_cnt = '0;
        req_sdata = '0;

        for (int i = 0; i < 1024; i++) expCache[i] = DATA_W'($urandom);
        for (int i = 0; i < 32; i++) expRf[i] = DATA_W'($urandom);
        expCache[5] = 16'hBEEF;

        // Reset held with a pending request.
        repeat (3) @(negedge clk);
        checkOutput("rstReady", req_ready, 0);
        checkOutput("rstCWrite", c_write, 0);
        checkOutput("rstRfWrite", rf_write, 0);
        checkOutput("rstDone", done, 0);
        doPreload = 1'b1;
        @(negedge clk);
        doPreload = 1'b0;
        Reset = 1'b1;
        req_valid = 1'b0;
        #1;
        checkOutput("releaseReadyLow", req_ready, 0);
        @(negedge clk);
        checkOutput("releaseReadyHigh", req_ready, 1);
        checkMemories("preload");

        // LW addr 5 into r3.
        applyStimulus(OP_LW, 10'd5, 5'd3, 3'd0, 16'h0, 1'b0, waited);
        checkOutput("lwR3", rfMem[3], 16'hBEEF);

        // SWM across address and register wrap.
        applyStimulus(OP_SWM, 10'd1022, 5'd30, 3'd3, 16'h0, 1'b0, waited);

        // LWM starting at r0: first beat suppressed.
        applyStimulus(OP_LWM, 10'd40, 5'd0, 3'd1, 16'h0, 1'b0, waited);

        // Back-to-back SW then LW of the same address with valid held.
        applyStimulus(OP_SW, 10'd77, 5'd0, 3'd5, 16'h1234, 1'b1, waited);
        applyStimulus(OP_LW, 10'd77, 5'd9, 3'd0, 16'h0, 1'b0, waited);
        checkOutput("b2bNoWait", waited, 0);
        checkOutput("b2bLoadValue", rfMem[9], 16'h1234);

        // Reset in the middle of an 8-word LWM after three beats.
        for (int i = 0; i < 3; i++) expRf[8 + i] = expCache[300 + i];
        req_op = OP_LWM;
        req_addr = 10'd300;
        req_reg = 5'd8;
        req_cnt = 3'd7;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        Reset = 1'b0;
        #1;
        checkOutput("abortCWrite", c_write, 0);
        checkOutput("abortRfWrite", rf_write, 0);
        checkOutput("abortDone", done, 0);
        checkOutput("abortReady", req_ready, 0);
        repeat (2) @(negedge clk);
        checkOutput("abortDoneHeld", done, 0);
        Reset = 1'b1;
        @(negedge clk);
        checkOutput("abortReadyBack", req_ready, 1);
        checkOutput("abortNoDone", done, 0);
        checkMemories("abort");
        applyStimulus(OP_LWM, 10'd500, 5'd20, 3'd2, 16'h0, 1'b0, waited);

        // Randomized requests against the model.
        for (int t = 0; t < 24; t++) begin
            applyStimulus(2'($urandom_range(0, 3)), CADDR_W'($urandom), RADDR_W'($urandom),
                          CNT_W'($urandom), DATA_W'($urandom), bit'($urandom_range(0, 1)), waited);
        end
        req_valid = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
